// File: rtl/butterfly3_32_pipe_if.sv
// Bus bundle for the 32-point first-stage butterfly: input vector with mode bits,
// and the registered output vector with row tagging.
interface butterfly3_32_pipe_if #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 28
);
    logic                    i_valid;
    logic                    enable;
    logic                    inverse;
    logic [1:0]              i_size;
    logic signed [IN_W-1:0]  i_0,  i_1,  i_2,  i_3,  i_4,  i_5,  i_6,  i_7;
    logic signed [IN_W-1:0]  i_8,  i_9,  i_10, i_11, i_12, i_13, i_14, i_15;
    logic signed [IN_W-1:0]  i_16, i_17, i_18, i_19, i_20, i_21, i_22, i_23;
    logic signed [IN_W-1:0]  i_24, i_25, i_26, i_27, i_28, i_29, i_30, i_31;

    logic                    o_valid;
    logic                    o_enable;
    logic                    o_inverse;
    logic [4:0]              o_row;
    logic                    o_last;
    logic signed [OUT_W-1:0] o_0,  o_1,  o_2,  o_3,  o_4,  o_5,  o_6,  o_7;
    logic signed [OUT_W-1:0] o_8,  o_9,  o_10, o_11, o_12, o_13, o_14, o_15;
    logic signed [OUT_W-1:0] o_16, o_17, o_18, o_19, o_20, o_21, o_22, o_23;
    logic signed [OUT_W-1:0] o_24, o_25, o_26, o_27, o_28, o_29, o_30, o_31;

    modport slave (
        input  i_valid, enable, inverse, i_size,
        input  i_0,  i_1,  i_2,  i_3,  i_4,  i_5,  i_6,  i_7,
        input  i_8,  i_9,  i_10, i_11, i_12, i_13, i_14, i_15,
        input  i_16, i_17, i_18, i_19, i_20, i_21, i_22, i_23,
        input  i_24, i_25, i_26, i_27, i_28, i_29, i_30, i_31,
        output o_valid, o_enable, o_inverse, o_row, o_last,
        output o_0,  o_1,  o_2,  o_3,  o_4,  o_5,  o_6,  o_7,
        output o_8,  o_9,  o_10, o_11, o_12, o_13, o_14, o_15,
        output o_16, o_17, o_18, o_19, o_20, o_21, o_22, o_23,
        output o_24, o_25, o_26, o_27, o_28, o_29, o_30, o_31
    );

    modport master (
        output i_valid, enable, inverse, i_size,
        output i_0,  i_1,  i_2,  i_3,  i_4,  i_5,  i_6,  i_7,
        output i_8,  i_9,  i_10, i_11, i_12, i_13, i_14, i_15,
        output i_16, i_17, i_18, i_19, i_20, i_21, i_22, i_23,
        output i_24, i_25, i_26, i_27, i_28, i_29, i_30, i_31,
        input  o_valid, o_enable, o_inverse, o_row, o_last,
        input  o_0,  o_1,  o_2,  o_3,  o_4,  o_5,  o_6,  o_7,
        input  o_8,  o_9,  o_10, o_11, o_12, o_13, o_14, o_15,
        input  o_16, o_17, o_18, o_19, o_20, o_21, o_22, o_23,
        input  o_24, o_25, o_26, o_27, o_28, o_29, o_30, o_31
    );
endinterface

// File: rtl/butterfly3_32_pipe.sv
// Registered 32-point first-stage DCT butterfly (sum/difference of mirrored samples)
// with per-vector mode capture and a block row counter.
module butterfly3_32_pipe #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 28
) (
    input  logic               clk,
    input  logic               rst,
    butterfly3_32_pipe_if.slave bus
);
    logic signed [IN_W-1:0]  w_in  [32];
    logic signed [OUT_W-1:0] w_res [32];
    logic signed [OUT_W-1:0] r_out [32];
    logic                    w_bfly;
    logic [4:0]              w_lim;
    logic                    w_last;
    logic [4:0]              r_cnt;
    logic                    r_valid;
    logic                    r_enable;
    logic                    r_inverse;
    logic [4:0]              r_row;
    logic                    r_last;

    assign w_in[0]  = bus.i_0;  assign w_in[1]  = bus.i_1;  assign w_in[2]  = bus.i_2;  assign w_in[3]  = bus.i_3;
    assign w_in[4]  = bus.i_4;  assign w_in[5]  = bus.i_5;  assign w_in[6]  = bus.i_6;  assign w_in[7]  = bus.i_7;
    assign w_in[8]  = bus.i_8;  assign w_in[9]  = bus.i_9;  assign w_in[10] = bus.i_10; assign w_in[11] = bus.i_11;
    assign w_in[12] = bus.i_12; assign w_in[13] = bus.i_13; assign w_in[14] = bus.i_14; assign w_in[15] = bus.i_15;
    assign w_in[16] = bus.i_16; assign w_in[17] = bus.i_17; assign w_in[18] = bus.i_18; assign w_in[19] = bus.i_19;
    assign w_in[20] = bus.i_20; assign w_in[21] = bus.i_21; assign w_in[22] = bus.i_22; assign w_in[23] = bus.i_23;
    assign w_in[24] = bus.i_24; assign w_in[25] = bus.i_25; assign w_in[26] = bus.i_26; assign w_in[27] = bus.i_27;
    assign w_in[28] = bus.i_28; assign w_in[29] = bus.i_29; assign w_in[30] = bus.i_30; assign w_in[31] = bus.i_31;

    assign w_bfly = bus.enable && !bus.inverse;

    always_comb begin
        for (int unsigned k = 0; k < 32; k++) begin
            w_res[k] = OUT_W'(w_in[k]);
        end
        if (w_bfly) begin
            for (int unsigned k = 0; k < 16; k++) begin
                w_res[k]      = OUT_W'(w_in[k]) + OUT_W'(w_in[31-k]);
                w_res[31-k]   = OUT_W'(w_in[k]) - OUT_W'(w_in[31-k]);
            end
        end
    end

    // Last row is (4 << size) - 1; a count already past a shrunken limit also ends the block.
    always_comb begin
        w_lim = 5'd31;
        unique case (bus.i_size)
            2'd0:    w_lim = 5'd3;
            2'd1:    w_lim = 5'd7;
            2'd2:    w_lim = 5'd15;
            default: w_lim = 5'd31;
        endcase
    end

    assign w_last = (r_cnt >= w_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_enable  <= 1'b0;
            r_inverse <= 1'b0;
            r_row     <= '0;
            r_last    <= 1'b0;
            r_cnt     <= '0;
            for (int unsigned k = 0; k < 32; k++) begin
                r_out[k] <= '0;
            end
        end else begin
            r_valid <= bus.i_valid;
            r_last  <= bus.i_valid && w_last;
            if (bus.i_valid) begin
                r_enable  <= bus.enable;
                r_inverse <= bus.inverse;
                r_row     <= r_cnt;
                r_cnt     <= w_last ? '0 : r_cnt + 5'd1;
                for (int unsigned k = 0; k < 32; k++) begin
                    r_out[k] <= w_res[k];
                end
            end
        end
    end

    assign bus.o_valid   = r_valid;
    assign bus.o_enable  = r_enable;
    assign bus.o_inverse = r_inverse;
    assign bus.o_row     = r_row;
    assign bus.o_last    = r_last;

    assign bus.o_0  = r_out[0];  assign bus.o_1  = r_out[1];  assign bus.o_2  = r_out[2];  assign bus.o_3  = r_out[3];
    assign bus.o_4  = r_out[4];  assign bus.o_5  = r_out[5];  assign bus.o_6  = r_out[6];  assign bus.o_7  = r_out[7];
    assign bus.o_8  = r_out[8];  assign bus.o_9  = r_out[9];  assign bus.o_10 = r_out[10]; assign bus.o_11 = r_out[11];
    assign bus.o_12 = r_out[12]; assign bus.o_13 = r_out[13]; assign bus.o_14 = r_out[14]; assign bus.o_15 = r_out[15];
    assign bus.o_16 = r_out[16]; assign bus.o_17 = r_out[17]; assign bus.o_18 = r_out[18]; assign bus.o_19 = r_out[19];
    assign bus.o_20 = r_out[20]; assign bus.o_21 = r_out[21]; assign bus.o_22 = r_out[22]; assign bus.o_23 = r_out[23];
    assign bus.o_24 = r_out[24]; assign bus.o_25 = r_out[25]; assign bus.o_26 = r_out[26]; assign bus.o_27 = r_out[27];
    assign bus.o_28 = r_out[28]; assign bus.o_29 = r_out[29]; assign bus.o_30 = r_out[30]; assign bus.o_31 = r_out[31];
endmodule

// File: tb/tb_butterfly3_32_pipe.sv
// Directed bench for butterfly3_32_pipe: arithmetic reference model plus literal spot checks.
module tb_butterfly3_32_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    butterfly3_32_pipe_if #(.IN_W(27), .OUT_W(28)) bif ();
    butterfly3_32_pipe #(.IN_W(27), .OUT_W(28)) dut (.clk(clk), .rst(rst), .bus(bif));

    logic               s_valid = 1'b0;
    logic               s_en    = 1'b0;
    logic               s_inv   = 1'b0;
    logic [1:0]         s_size  = 2'd0;
    logic signed [26:0] s_in [32];
    logic signed [27:0] w_o  [32];

    assign bif.i_valid = s_valid; assign bif.enable = s_en; assign bif.inverse = s_inv; assign bif.i_size = s_size;
    assign bif.i_0  = s_in[0];  assign bif.i_1  = s_in[1];  assign bif.i_2  = s_in[2];  assign bif.i_3  = s_in[3];
    assign bif.i_4  = s_in[4];  assign bif.i_5  = s_in[5];  assign bif.i_6  = s_in[6];  assign bif.i_7  = s_in[7];
    assign bif.i_8  = s_in[8];  assign bif.i_9  = s_in[9];  assign bif.i_10 = s_in[10]; assign bif.i_11 = s_in[11];
    assign bif.i_12 = s_in[12]; assign bif.i_13 = s_in[13]; assign bif.i_14 = s_in[14]; assign bif.i_15 = s_in[15];
    assign bif.i_16 = s_in[16]; assign bif.i_17 = s_in[17]; assign bif.i_18 = s_in[18]; assign bif.i_19 = s_in[19];
    assign bif.i_20 = s_in[20]; assign bif.i_21 = s_in[21]; assign bif.i_22 = s_in[22]; assign bif.i_23 = s_in[23];
    assign bif.i_24 = s_in[24]; assign bif.i_25 = s_in[25]; assign bif.i_26 = s_in[26]; assign bif.i_27 = s_in[27];
    assign bif.i_28 = s_in[28]; assign bif.i_29 = s_in[29]; assign bif.i_30 = s_in[30]; assign bif.i_31 = s_in[31];
    assign w_o[0]  = bif.o_0;  assign w_o[1]  = bif.o_1;  assign w_o[2]  = bif.o_2;  assign w_o[3]  = bif.o_3;
    assign w_o[4]  = bif.o_4;  assign w_o[5]  = bif.o_5;  assign w_o[6]  = bif.o_6;  assign w_o[7]  = bif.o_7;
    assign w_o[8]  = bif.o_8;  assign w_o[9]  = bif.o_9;  assign w_o[10] = bif.o_10; assign w_o[11] = bif.o_11;
    assign w_o[12] = bif.o_12; assign w_o[13] = bif.o_13; assign w_o[14] = bif.o_14; assign w_o[15] = bif.o_15;
    assign w_o[16] = bif.o_16; assign w_o[17] = bif.o_17; assign w_o[18] = bif.o_18; assign w_o[19] = bif.o_19;
    assign w_o[20] = bif.o_20; assign w_o[21] = bif.o_21; assign w_o[22] = bif.o_22; assign w_o[23] = bif.o_23;
    assign w_o[24] = bif.o_24; assign w_o[25] = bif.o_25; assign w_o[26] = bif.o_26; assign w_o[27] = bif.o_27;
    assign w_o[28] = bif.o_28; assign w_o[29] = bif.o_29; assign w_o[30] = bif.o_30; assign w_o[31] = bif.o_31;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: outputs one edge after each accepted vector, computed from the transform rules.
    longint m_o [32];
    logic   m_valid, m_en, m_inv, m_last;
    int     m_row, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_en <= 1'b0; m_inv <= 1'b0; m_last <= 1'b0;
            m_row <= 0; m_cnt <= 0;
            for (int k = 0; k < 32; k++) m_o[k] <= 0;
        end else begin
            m_valid <= s_valid;
            m_last  <= 1'b0;
            if (s_valid) begin
                int lim;
                lim = (4 << s_size) - 1;
                m_en <= s_en; m_inv <= s_inv;
                m_row <= m_cnt;
                m_last <= (m_cnt >= lim);
                m_cnt <= (m_cnt >= lim) ? 0 : m_cnt + 1;
                for (int k = 0; k < 32; k++) begin
                    if (s_en && !s_inv)
                        m_o[k] <= (k < 16) ? longint'(s_in[k]) + longint'(s_in[31-k])
                                           : longint'(s_in[31-k]) - longint'(s_in[k]);
                    else
                        m_o[k] <= longint'(s_in[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int bad;
            bad = -1;
            check("o_valid", longint'(bif.o_valid), longint'(m_valid));
            check("o_enable", longint'(bif.o_enable), longint'(m_en));
            check("o_inverse", longint'(bif.o_inverse), longint'(m_inv));
            check("o_row", longint'(bif.o_row), longint'(m_row));
            check("o_last", longint'(bif.o_last), longint'(m_last));
            for (int k = 31; k >= 0; k--) if (longint'(w_o[k]) != m_o[k]) bad = k;
            if (bad >= 0) check($sformatf("o_%0d", bad), longint'(w_o[bad]), m_o[bad]);
            else check("o_vector", 0, 0 * longint'(w_o[0]) + longint'(w_o[0]) - m_o[0]);
        end
    end

    task automatic cyc(input logic v, input logic en, input logic inv, input logic [1:0] sz);
        s_valid = v; s_en = en; s_inv = inv; s_size = sz;
        @(posedge clk); #1;
    endtask

    task automatic ramp();
        for (int k = 0; k < 32; k++) s_in[k] = 27'(k);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) s_in[k] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset o_valid", longint'(bif.o_valid), 0);
        check("reset o_row", longint'(bif.o_row), 0);
        check("reset o_0", longint'(w_o[0]), 0);

        ramp();
        cyc(1, 1, 0, 2'd3);
        check("bfly o_0", longint'(w_o[0]), 31);
        check("bfly o_15", longint'(w_o[15]), 31);
        check("bfly o_16", longint'(w_o[16]), -1);
        check("bfly o_17", longint'(w_o[17]), -3);
        check("bfly o_31", longint'(w_o[31]), -31);
        check("bfly o_valid", longint'(bif.o_valid), 1);

        for (int k = 0; k < 32; k++) s_in[k] = '0;
        s_in[0] = -27'sd67108864; s_in[31] = -27'sd67108864;
        cyc(1, 1, 0, 2'd3);
        check("ext o_0", longint'(w_o[0]), -134217728);
        check("ext o_31", longint'(w_o[31]), 0);
        s_in[0] = 27'sd67108863;
        cyc(1, 1, 0, 2'd3);
        check("ext2 o_31", longint'(w_o[31]), 134217727);
        check("ext2 o_0", longint'(w_o[0]), -1);

        ramp();
        cyc(0, 0, 1, 2'd3);
        check("idle o_valid", longint'(bif.o_valid), 0);
        check("idle hold o_31", longint'(w_o[31]), 134217727);

        cyc(1, 0, 0, 2'd3);
        check("pass o_5", longint'(w_o[5]), 5);
        check("pass o_enable", longint'(bif.o_enable), 0);
        cyc(1, 1, 1, 2'd3);
        check("inv o_20", longint'(w_o[20]), 20);
        check("inv o_inverse", longint'(bif.o_inverse), 1);
        cyc(1, 1, 0, 2'd3);
        check("mode o_5", longint'(w_o[5]), 31);
        check("mode o_enable", longint'(bif.o_enable), 1);
        check("mode o_inverse", longint'(bif.o_inverse), 0);
        cyc(1, 0, 1, 2'd3);
        check("mode2 o_30", longint'(w_o[30]), 30);

        #3 rst = 1'b1;
        #1;
        check("async o_valid", longint'(bif.o_valid), 0);
        check("async o_row", longint'(bif.o_row), 0);
        check("async o_5", longint'(w_o[5]), 0);
        check("async o_enable", longint'(bif.o_enable), 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int r = 0; r < 8; r++) begin
            cyc(1, 1, 0, 2'd1);
            check("row8 o_row", longint'(bif.o_row), longint'(r));
            check("row8 o_last", longint'(bif.o_last), (r == 7) ? 1 : 0);
            if (r % 2 == 1) begin
                cyc(0, 1, 0, 2'd1);
                check("bubble o_last", longint'(bif.o_last), 0);
            end
        end
        cyc(1, 1, 0, 2'd1);
        check("row9 o_row", longint'(bif.o_row), 0);

        for (int r = 1; r < 10; r++) cyc(1, 0, 0, 2'd3);
        check("pre o_row", longint'(bif.o_row), 9);
        check("pre o_last", longint'(bif.o_last), 0);
        cyc(1, 0, 0, 2'd0);
        check("shrink o_row", longint'(bif.o_row), 10);
        check("shrink o_last", longint'(bif.o_last), 1);
        cyc(1, 0, 0, 2'd0);
        check("after o_row", longint'(bif.o_row), 0);
        check("after o_last", longint'(bif.o_last), 0);

        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 32; k++) s_in[k] = 27'($urandom);
            cyc(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom));
        end
        cyc(0, 0, 0, 2'd0);
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
